// File: rtl/core_wb_pkg.sv
// Shared types for the write-back stage: FSM state encoding and load funct3 codes.
package core_wb_pkg;

  typedef enum logic [1:0] {
    WbIdle     = 2'd0,
    WbWaitLoad = 2'd1,
    WbWrite    = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/core_wb_if.sv
// EX-result handshake and memory-response bus feeding the write-back stage.
interface core_wb_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  ex_valid_in;
  logic                  ex_ready_out;
  logic                  ex_we_in;
  logic [REG_ADDR_W-1:0] ex_rd_in;
  logic [XLEN-1:0]       ex_data_in;
  logic                  ex_is_load_in;
  logic [2:0]            ex_funct3_in;
  logic [1:0]            ex_addr_lo_in;
  logic                  mem_rvalid_in;
  logic [XLEN-1:0]       mem_rdata_in;

  modport master (
    output ex_valid_in, ex_we_in, ex_rd_in, ex_data_in, ex_is_load_in,
           ex_funct3_in, ex_addr_lo_in, mem_rvalid_in, mem_rdata_in,
    input  ex_ready_out
  );

  modport slave (
    input  ex_valid_in, ex_we_in, ex_rd_in, ex_data_in, ex_is_load_in,
           ex_funct3_in, ex_addr_lo_in, mem_rvalid_in, mem_rdata_in,
    output ex_ready_out
  );
endinterface

// File: rtl/core_wb_load_ext.sv
// Combinational load-data extraction: picks byte/halfword by addr_lo and sign/zero extends.
module core_wb_load_ext
  import core_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data
);

  logic [7:0]  bytes [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign bytes[gi] = rdata[gi*8 +: 8];
    end
  endgenerate

  assign sel_byte = bytes[addr_lo];
  // Halfword selection ignores addr_lo[0]; misaligned halves are not trapped here.
  assign sel_half = addr_lo[1] ? {bytes[3], bytes[2]} : {bytes[1], bytes[0]};

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, sel_byte};
      F3_LH:   data = {{(XLEN-16){sel_half[15]}}, sel_half};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, sel_half};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/core_wb.sv
// Write-back stage: registers EX results, waits for load data, drives the register-file port.
// Define CORE_WB_BYPASS_EN to mirror the write port onto the fwd_* outputs.
module core_wb
  import core_wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  core_wb_if.slave              bus,
  output logic                  we_out,
  output logic [REG_ADDR_W-1:0] write_addr_out,
  output logic [XLEN-1:0]       write_data_out,
  output logic                  load_pending_out,
  output logic [REG_ADDR_W-1:0] load_rd_out,
  output logic                  fwd_valid_out,
  output logic [REG_ADDR_W-1:0] fwd_addr_out,
  output logic [XLEN-1:0]       fwd_data_out,
  output logic                  err_out
);

  localparam int CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

  wb_state_e             state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  ld_we_reg, ld_we_next;
  logic [REG_ADDR_W-1:0] ld_rd_reg, ld_rd_next;
  logic [2:0]            ld_f3_reg, ld_f3_next;
  logic [1:0]            ld_lo_reg, ld_lo_next;
  logic                  we_reg, we_next;
  logic [REG_ADDR_W-1:0] addr_reg, addr_next;
  logic [XLEN-1:0]       data_reg, data_next;
  logic                  err_reg, err_next;
  logic [XLEN-1:0]       ext_data;
  logic                  ready;
  logic                  xfer;

  core_wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata   (bus.mem_rdata_in),
    .funct3  (ld_f3_reg),
    .addr_lo (ld_lo_reg),
    .data    (ext_data)
  );

  assign ready            = (state_reg != WbWaitLoad);
  assign xfer             = bus.ex_valid_in & ready;
  assign bus.ex_ready_out = ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ld_we_next = ld_we_reg;
    ld_rd_next = ld_rd_reg;
    ld_f3_next = ld_f3_reg;
    ld_lo_next = ld_lo_reg;
    we_next    = 1'b0;
    addr_next  = '0;
    data_next  = '0;
    err_next   = 1'b0;
    case (state_reg)
      WbIdle, WbWrite: begin
        if (xfer && bus.ex_is_load_in) begin
          state_next = WbWaitLoad;
          cnt_next   = '0;
          ld_we_next = bus.ex_we_in;
          ld_rd_next = bus.ex_rd_in;
          ld_f3_next = bus.ex_funct3_in;
          ld_lo_next = bus.ex_addr_lo_in;
        end else if (xfer) begin
          state_next = WbWrite;
          we_next    = bus.ex_we_in & (bus.ex_rd_in != '0);
          addr_next  = bus.ex_rd_in;
          data_next  = bus.ex_data_in;
        end else begin
          state_next = WbIdle;
        end
      end
      WbWaitLoad: begin
        // A response arriving on the final counted cycle still completes the load.
        if (bus.mem_rvalid_in) begin
          state_next = WbWrite;
          cnt_next   = '0;
          we_next    = ld_we_reg & (ld_rd_reg != '0);
          addr_next  = ld_rd_reg;
          data_next  = ext_data;
        end else if (cnt_reg == CNT_W'(LOAD_TIMEOUT - 1)) begin
          state_next = WbIdle;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = WbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= WbIdle;
      cnt_reg   <= '0;
      ld_we_reg <= 1'b0;
      ld_rd_reg <= '0;
      ld_f3_reg <= '0;
      ld_lo_reg <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ld_we_reg <= ld_we_next;
      ld_rd_reg <= ld_rd_next;
      ld_f3_reg <= ld_f3_next;
      ld_lo_reg <= ld_lo_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  assign we_out           = we_reg;
  assign write_addr_out   = addr_reg;
  assign write_data_out   = data_reg;
  assign err_out          = err_reg;
  assign load_pending_out = (state_reg == WbWaitLoad);
  assign load_rd_out      = load_pending_out ? ld_rd_reg : '0;

`ifdef CORE_WB_BYPASS_EN
  assign fwd_valid_out = we_reg;
  assign fwd_addr_out  = addr_reg;
  assign fwd_data_out  = data_reg;
`else
  assign fwd_valid_out = 1'b0;
  assign fwd_addr_out  = '0;
  assign fwd_data_out  = '0;
`endif

endmodule

// File: tb/tb_core_wb.sv
// Self-checking bench for core_wb: directed and random ALU/load traffic against a behavioural model.
module tb_core_wb;
  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int TMO  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           we_out;
  logic [RAW-1:0] write_addr_out;
  logic [31:0]    write_data_out;
  logic           load_pending_out;
  logic [RAW-1:0] load_rd_out;
  logic           fwd_valid_out;
  logic [RAW-1:0] fwd_addr_out;
  logic [31:0]    fwd_data_out;
  logic           err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_wb_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) bus ();

  core_wb #(.XLEN(XLEN), .REG_ADDR_W(RAW), .LOAD_TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .we_out           (we_out),
    .write_addr_out   (write_addr_out),
    .write_data_out   (write_data_out),
    .load_pending_out (load_pending_out),
    .load_rd_out      (load_rd_out),
    .fwd_valid_out    (fwd_valid_out),
    .fwd_addr_out     (fwd_addr_out),
    .fwd_data_out     (fwd_data_out),
    .err_out          (err_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference load result: shift the addressed unit down, then extend through signed/unsigned casts.
  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] bsh;
    logic [31:0] hsh;
    byte         sb;
    shortint     sh;
    bsh = w >> (8 * lo);
    hsh = w >> (16 * lo[1]);
    sb  = byte'(bsh);
    sh  = shortint'(hsh);
    case (f3)
      3'd0:    return 32'(int'(sb));
      3'd4:    return bsh & 32'h0000_00FF;
      3'd1:    return 32'(int'(sh));
      3'd5:    return hsh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ex_valid_in   = 1'b0;
    bus.ex_we_in      = 1'b0;
    bus.ex_rd_in      = '0;
    bus.ex_data_in    = '0;
    bus.ex_is_load_in = 1'b0;
    bus.ex_funct3_in  = '0;
    bus.ex_addr_lo_in = '0;
    bus.mem_rvalid_in = 1'b0;
    bus.mem_rdata_in  = '0;
  endtask

  task automatic check_wr(input string tag, input bit exp_we, input logic [RAW-1:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(we_out), 32'(exp_we));
    if (exp_we) begin
      chk({tag, ".addr"}, 32'(write_addr_out), 32'(a));
      chk({tag, ".data"}, write_data_out, d);
    end
    chk({tag, ".err"}, 32'(err_out), 32'd0);
`ifdef CORE_WB_BYPASS_EN
    chk({tag, ".fwd_v"}, 32'(fwd_valid_out), 32'(exp_we));
    if (exp_we) begin
      chk({tag, ".fwd_a"}, 32'(fwd_addr_out), 32'(a));
      chk({tag, ".fwd_d"}, fwd_data_out, d);
    end
`else
    chk({tag, ".fwd_v"}, 32'(fwd_valid_out), 32'd0);
    chk({tag, ".fwd_a"}, 32'(fwd_addr_out), 32'd0);
    chk({tag, ".fwd_d"}, fwd_data_out, 32'd0);
`endif
  endtask

  // Presents one ALU result, clocks it in and checks the write appears in the next cycle.
  task automatic send_alu(input string tag, input logic [RAW-1:0] rd, input logic [31:0] d, input bit we);
    bus.ex_valid_in   = 1'b1;
    bus.ex_is_load_in = 1'b0;
    bus.ex_we_in      = we;
    bus.ex_rd_in      = rd;
    bus.ex_data_in    = d;
    chk({tag, ".ready"}, 32'(bus.ex_ready_out), 32'd1);
    tick();
    check_wr(tag, we && (rd != 0), rd, d);
    $display("ALU  %s rd=%0d data=%08h we=%0d", tag, rd, d, we);
  endtask

  task automatic finish_alu(input string tag);
    idle_in();
    tick();
    check_wr({tag, ".end"}, 1'b0, '0, '0);
  endtask

  // delay = number of WAIT_LOAD cycles before rvalid; delay >= TMO means no response (timeout).
  task automatic do_load(input string tag, input logic [RAW-1:0] rd, input logic [2:0] f3,
                         input logic [1:0] lo, input logic [31:0] w, input int delay, input bit we);
    int waits;
    bus.ex_valid_in   = 1'b1;
    bus.ex_is_load_in = 1'b1;
    bus.ex_we_in      = we;
    bus.ex_rd_in      = rd;
    bus.ex_funct3_in  = f3;
    bus.ex_addr_lo_in = lo;
    bus.ex_data_in    = $urandom;
    chk({tag, ".ready0"}, 32'(bus.ex_ready_out), 32'd1);
    tick();
    idle_in();
    bus.mem_rdata_in = $urandom;
    waits = (delay < TMO) ? delay : TMO;
    for (int i = 0; i < waits; i++) begin
      chk({tag, ".pend"}, 32'(load_pending_out), 32'd1);
      chk({tag, ".lrd"}, 32'(load_rd_out), 32'(rd));
      chk({tag, ".busy"}, 32'(bus.ex_ready_out), 32'd0);
      chk({tag, ".nowr"}, 32'(we_out), 32'd0);
      tick();
    end
    if (delay < TMO) begin
      bus.mem_rvalid_in = 1'b1;
      bus.mem_rdata_in  = w;
      chk({tag, ".pend_rv"}, 32'(load_pending_out), 32'd1);
      tick();
      idle_in();
      check_wr(tag, we && (rd != 0), rd, ref_ext(w, f3, lo));
      chk({tag, ".pend_done"}, 32'(load_pending_out), 32'd0);
      chk({tag, ".ready_done"}, 32'(bus.ex_ready_out), 32'd1);
    end else begin
      chk({tag, ".err"}, 32'(err_out), 32'd1);
      chk({tag, ".tmo_we"}, 32'(we_out), 32'd0);
      chk({tag, ".tmo_pend"}, 32'(load_pending_out), 32'd0);
      chk({tag, ".tmo_ready"}, 32'(bus.ex_ready_out), 32'd1);
      // A late response after the timeout must not produce a write.
      bus.mem_rvalid_in = 1'b1;
      bus.mem_rdata_in  = w;
      tick();
      idle_in();
      chk({tag, ".err_once"}, 32'(err_out), 32'd0);
      chk({tag, ".late_rv"}, 32'(we_out), 32'd0);
    end
    $display("LOAD %s rd=%0d f3=%0d lo=%0d word=%08h delay=%0d we=%0d", tag, rd, f3, lo, w, delay, we);
  endtask

  initial begin
    idle_in();
    rst = 1'b0;
    tick();
    tick();
    chk("rst.we", 32'(we_out), 32'd0);
    chk("rst.addr", 32'(write_addr_out), 32'd0);
    chk("rst.data", write_data_out, 32'd0);
    chk("rst.pend", 32'(load_pending_out), 32'd0);
    chk("rst.lrd", 32'(load_rd_out), 32'd0);
    chk("rst.err", 32'(err_out), 32'd0);
    chk("rst.ready", 32'(bus.ex_ready_out), 32'd1);
    chk("rst.fwd", 32'(fwd_valid_out), 32'd0);
    rst = 1'b1;
    tick();

    send_alu("add", 5'd5, 32'h1234, 1'b1);
    finish_alu("add");

    send_alu("b2b1", 5'd1, 32'hA1, 1'b1);
    send_alu("b2b2", 5'd2, 32'hB2, 1'b1);
    send_alu("b2b3", 5'd3, 32'hC3, 1'b1);
    finish_alu("b2b");

    do_load("lb", 5'd9, 3'b000, 2'd3, 32'h80AABBCC, 3, 1'b1);
    do_load("lbu", 5'd10, 3'b100, 2'd3, 32'h80AABBCC, 2, 1'b1);
    do_load("lh", 5'd11, 3'b001, 2'd2, 32'h80AABBCC, 1, 1'b1);
    do_load("lhu", 5'd12, 3'b101, 2'd0, 32'h1234F00D, 0, 1'b1);
    do_load("lw", 5'd13, 3'b010, 2'd1, 32'hDEADBEEF, 4, 1'b1);
    do_load("tmo", 5'd14, 3'b010, 2'd0, 32'h5555AAAA, TMO, 1'b1);
    do_load("rv16", 5'd15, 3'b010, 2'd0, 32'h600DF00D, TMO - 1, 1'b1);

    send_alu("x0alu", 5'd0, 32'hFFFF, 1'b1);
    finish_alu("x0alu");
    do_load("x0ld", 5'd0, 3'b010, 2'd0, 32'h01020304, 5, 1'b1);

    // Reset asserted in the middle of WAIT_LOAD.
    bus.ex_valid_in   = 1'b1;
    bus.ex_is_load_in = 1'b1;
    bus.ex_we_in      = 1'b1;
    bus.ex_rd_in      = 5'd7;
    tick();
    idle_in();
    tick();
    chk("mrst.pend_before", 32'(load_pending_out), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mrst.pend", 32'(load_pending_out), 32'd0);
    chk("mrst.lrd", 32'(load_rd_out), 32'd0);
    chk("mrst.ready", 32'(bus.ex_ready_out), 32'd1);
    chk("mrst.we", 32'(we_out), 32'd0);
    tick();
    rst = 1'b1;
    bus.mem_rvalid_in = 1'b1;
    bus.mem_rdata_in  = 32'hCAFEBABE;
    tick();
    idle_in();
    chk("mrst.late_rv", 32'(we_out), 32'd0);
    $display("RST  mid-load reset on rd=7");

    for (int i = 0; i < 8; i++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        send_alu($sformatf("ralu%0d_%0d", i, k), 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      finish_alu($sformatf("ralu%0d", i));
    end

    for (int i = 0; i < 24; i++) begin
      do_load($sformatf("rld%0d", i), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), $urandom, $urandom_range(0, TMO + 1), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
